// File: rtl/bank_tracker_pkg.sv
// Shared widths, the tracker entry layout and the latency saturation helper
// for the per-bank response tracker.
package bank_tracker_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int ID_W   = 32;
   localparam int CYC_W  = 64;
   localparam int LAT_W  = 32;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              is_write;
      logic [ID_W-1:0]   id;
      logic [CYC_W-1:0]  issue_cycle;
      logic [DATA_W-1:0] data;
      logic [LAT_W-1:0]  latency;
      logic              done;
   } entry_t;

   // Cycle differences that do not fit the latency field clamp to all-ones.
   function automatic logic [LAT_W-1:0] sat_latency(input logic [CYC_W-1:0] diff);
      if (diff[CYC_W-1:LAT_W] != '0) return '1;
      return diff[LAT_W-1:0];
   endfunction

endpackage

// File: rtl/bank_tracker_entry_ram.sv
// Register array of tracker entries: allocate and fill write ports, a done-clear
// port and a read port at the head, plus the issue cycle of the fill entry.
module bank_tracker_entry_ram
   import bank_tracker_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alloc_en,
   input  logic [$clog2(DEPTH)-1:0] alloc_ptr,
   input  logic [ADDR_W-1:0]        alloc_addr,
   input  logic                     alloc_is_write,
   input  logic [ID_W-1:0]          alloc_id,
   input  logic [CYC_W-1:0]         alloc_cycle,
   input  logic                     fill_en,
   input  logic [$clog2(DEPTH)-1:0] fill_ptr,
   input  logic [DATA_W-1:0]        fill_data,
   input  logic [LAT_W-1:0]         fill_latency,
   output logic [CYC_W-1:0]         fill_issue_cycle,
   input  logic                     clear_en,
   input  logic [$clog2(DEPTH)-1:0] head_ptr,
   output entry_t                   head_entry
);

   entry_t mem_q [DEPTH];
   entry_t mem_d [DEPTH];

   always_comb begin
      mem_d = mem_q;
      if (alloc_en) begin
         mem_d[alloc_ptr].addr        = alloc_addr;
         mem_d[alloc_ptr].is_write    = alloc_is_write;
         mem_d[alloc_ptr].id          = alloc_id;
         mem_d[alloc_ptr].issue_cycle = alloc_cycle;
         mem_d[alloc_ptr].done        = 1'b0;
      end
      if (fill_en) begin
         mem_d[fill_ptr].data    = fill_data;
         mem_d[fill_ptr].latency = fill_latency;
         mem_d[fill_ptr].done    = 1'b1;
      end
      if (clear_en) mem_d[head_ptr].done = 1'b0;
   end

   // NOTE: only the done bits are reset; payload fields are always written
   // before done is set, so resetting them would only add reset fanout.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i].done <= 1'b0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign head_entry       = mem_q[head_ptr];
   assign fill_issue_cycle = mem_q[fill_ptr].issue_cycle;

endmodule

// File: rtl/bank_response_tracker.sv
// In-order per-bank request/response tracker: tags requests with an ID and issue
// cycle, attaches in-order completions and presents them through valid/ready.
module bank_response_tracker
   import bank_tracker_pkg::*;
#(
   parameter int RANK      = 0,
   parameter int BANKGROUP = 0,
   parameter int BANK      = 0,
   parameter int DEPTH     = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_is_write,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_fire,
   output logic [ADDR_W-1:0] resp_addr,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_is_write,
   output logic [ID_W-1:0]   resp_request_id,
   output logic [LAT_W-1:0]  resp_latency,
   output logic [CYC_W-1:0]  global_cycle,
   output logic              proto_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
   logic [PTR_W-1:0] head_ptr_q,  head_ptr_d;
   logic [CNT_W-1:0] count_q,     count_d;
   logic [CNT_W-1:0] pend_q,      pend_d;
   logic [ID_W-1:0]  req_id_q,    req_id_d;
   logic [CYC_W-1:0] cycle_q,     cycle_d;
   logic             proto_err_q, proto_err_d;

   logic             accept;
   logic             fill_en;
   logic             stray;
   logic [CYC_W-1:0] fill_issue_cycle;
   entry_t           head_entry;

   assign req_ready  = reset && (count_q < CNT_W'(DEPTH));
   assign accept     = req_valid && req_ready;
   // Pending is tracked separately so a full, all-outstanding queue (fill == alloc)
   // still accepts completions; a request accepted this cycle is not yet pending.
   assign fill_en    = reset && mem_resp_valid && (pend_q != '0);
   assign stray      = reset && mem_resp_valid && (pend_q == '0);
   assign resp_valid = reset && head_entry.done;
   assign resp_fire  = resp_valid && resp_ready;

   // NOTE: next-state logic uses blocking assignments in always_comb with every
   // target defaulted first; only the always_ff below uses non-blocking updates.
   always_comb begin
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      head_ptr_d  = head_ptr_q;
      if (accept)    alloc_ptr_d = alloc_ptr_q + 1'b1;
      if (fill_en)   fill_ptr_d  = fill_ptr_q + 1'b1;
      if (resp_fire) head_ptr_d  = head_ptr_q + 1'b1;
      count_d     = count_q + CNT_W'(accept) - CNT_W'(resp_fire);
      pend_d      = pend_q + CNT_W'(accept) - CNT_W'(fill_en);
      req_id_d    = req_id_q + ID_W'(accept);
      cycle_d     = cycle_q + 1'b1;
      proto_err_d = proto_err_q || stray;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         pend_q      <= '0;
         req_id_q    <= '0;
         cycle_q     <= '0;
         proto_err_q <= 1'b0;
      end else begin
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         head_ptr_q  <= head_ptr_d;
         count_q     <= count_d;
         pend_q      <= pend_d;
         req_id_q    <= req_id_d;
         cycle_q     <= cycle_d;
         proto_err_q <= proto_err_d;
      end
   end

   bank_tracker_entry_ram #(.DEPTH(DEPTH)) u_entry_ram (
      .clk              (clk),
      .reset            (reset),
      .alloc_en         (accept),
      .alloc_ptr        (alloc_ptr_q),
      .alloc_addr       (req_addr),
      .alloc_is_write   (req_is_write),
      .alloc_id         (req_id_q),
      .alloc_cycle      (cycle_q),
      .fill_en          (fill_en),
      .fill_ptr         (fill_ptr_q),
      .fill_data        (mem_resp_data),
      .fill_latency     (sat_latency(cycle_q - fill_issue_cycle)),
      .fill_issue_cycle (fill_issue_cycle),
      .clear_en         (resp_fire),
      .head_ptr         (head_ptr_q),
      .head_entry       (head_entry)
   );

   // Every output reads zero while reset is held, including unreset payload fields.
   assign resp_addr       = reset ? head_entry.addr     : '0;
   assign resp_data       = reset ? head_entry.data     : '0;
   assign resp_is_write   = reset && head_entry.is_write;
   assign resp_request_id = reset ? head_entry.id       : '0;
   assign resp_latency    = reset ? head_entry.latency  : '0;
   assign global_cycle    = reset ? cycle_q             : '0;
   assign proto_err       = reset && proto_err_q;

   logic unused_ok;
   assign unused_ok = ^{RANK, BANKGROUP, BANK, head_entry.issue_cycle};

endmodule

// File: tb/tb_bank_response_tracker.sv
// Directed bench for bank_response_tracker: each scenario task drives stimulus
// and compares outputs against hand-computed values.
module tb_bank_response_tracker;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_is_write;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_fire;
   logic [31:0] resp_addr;
   logic [31:0] resp_data;
   logic        resp_is_write;
   logic [31:0] resp_request_id;
   logic [31:0] resp_latency;
   logic [63:0] global_cycle;
   logic        proto_err;

   int vectors     = 0;
   int miscompares = 0;
   int exp_cycle   = 0;

   bank_response_tracker #(.RANK(0), .BANKGROUP(0), .BANK(0), .DEPTH(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_is_write    (req_is_write),
      .mem_resp_valid  (mem_resp_valid),
      .mem_resp_data   (mem_resp_data),
      .resp_valid      (resp_valid),
      .resp_ready      (resp_ready),
      .resp_fire       (resp_fire),
      .resp_addr       (resp_addr),
      .resp_data       (resp_data),
      .resp_is_write   (resp_is_write),
      .resp_request_id (resp_request_id),
      .resp_latency    (resp_latency),
      .global_cycle    (global_cycle),
      .proto_err       (proto_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      exp_cycle++;
   endtask

   task automatic clear_inputs();
      req_valid      = 1'b0;
      req_addr       = '0;
      req_is_write   = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      resp_ready     = 1'b0;
   endtask

   // Leaves the bench in cycle 0 (global_cycle == 0) with reset released.
   task automatic do_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      reset     = 1'b1;
      exp_cycle = 0;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      tick();
      tick();
      #1;
      vectors++;
      if ({req_ready, resp_valid, resp_fire, resp_addr, resp_data, resp_is_write,
           resp_request_id, resp_latency, global_cycle, proto_err} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b cyc=%0d err=%b required all zero",
                  req_ready, resp_valid, global_cycle, proto_err);
      end
      reset     = 1'b1;
      exp_cycle = 0;
      #1;
      vectors++;
      if ({req_ready, global_cycle} !== {1'b1, 64'd0}) begin
         miscompares++;
         $display("FAIL reset_release: got rdy=%b cyc=%0d required rdy=1 cyc=0", req_ready, global_cycle);
      end
   endtask

   task automatic test_single_read();
      do_reset();
      repeat (10) tick();
      vectors++;
      if (global_cycle !== 64'd10) begin
         miscompares++;
         $display("FAIL single_cycle10: got %0d required 10", global_cycle);
      end
      req_valid = 1'b1; req_addr = 32'h40; req_is_write = 1'b0;
      tick();
      req_valid = 1'b0;
      repeat (14) tick();
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_early_valid: got %b required 0", resp_valid);
      end
      mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD;
      tick();
      mem_resp_valid = 1'b0;
      vectors++;
      if ({resp_valid, resp_request_id, resp_latency, resp_data, resp_addr, resp_is_write}
          !== {1'b1, 32'd0, 32'd15, 32'hDEAD, 32'h40, 1'b0}) begin
         miscompares++;
         $display("FAIL single_resp: got vld=%b id=%0d lat=%0d data=%h addr=%h wr=%b required 1 0 15 dead 40 0",
                  resp_valid, resp_request_id, resp_latency, resp_data, resp_addr, resp_is_write);
      end
      resp_ready = 1'b1;
      #1;
      vectors++;
      if (resp_fire !== 1'b1) begin
         miscompares++;
         $display("FAIL single_fire: got %b required 1", resp_fire);
      end
      tick();
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL single_drained: got %b required 0", resp_valid);
      end
   endtask

   task automatic test_full();
      do_reset();
      req_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         req_addr = 32'h100 + 32'(i * 4); req_is_write = i[0];
         #1;
         vectors++;
         if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL full_ready_%0d: got %b required 1", i, req_ready);
         end
         tick();
      end
      req_addr = 32'h1FC;
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL full_not_ready: got %b required 0", req_ready);
      end
      tick();
      req_valid      = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h1111_0000;
      tick();
      mem_resp_valid = 1'b0;
      vectors++;
      if ({resp_valid, resp_request_id, resp_addr, resp_latency, proto_err, req_ready}
          !== {1'b1, 32'd0, 32'h100, 32'd9, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL full_head: got vld=%b id=%0d addr=%h lat=%0d err=%b rdy=%b required 1 0 100 9 0 0",
                  resp_valid, resp_request_id, resp_addr, resp_latency, proto_err, req_ready);
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      vectors++;
      if ({req_ready, resp_valid, resp_request_id} !== {1'b1, 1'b0, 32'd1}) begin
         miscompares++;
         $display("FAIL full_reopen: got rdy=%b vld=%b id=%0d required rdy=1 vld=0 id=1",
                  req_ready, resp_valid, resp_request_id);
      end
   endtask

   task automatic test_back_pressure();
      logic [31:0] dat [3];
      dat[0] = 32'hA0; dat[1] = 32'hA1; dat[2] = 32'hA2;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_addr = 32'h200 + 32'(i * 4); req_is_write = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mem_resp_valid = 1'b1; mem_resp_data = dat[i];
         tick();
      end
      mem_resp_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         vectors++;
         if ({resp_valid, resp_request_id, resp_addr, resp_data, resp_latency, resp_fire}
             !== {1'b1, 32'd0, 32'h200, 32'hA0, 32'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL bp_hold_%0d: got vld=%b id=%0d addr=%h data=%h lat=%0d fire=%b required 1 0 200 a0 3 0",
                     k, resp_valid, resp_request_id, resp_addr, resp_data, resp_latency, resp_fire);
         end
         tick();
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++;
         if ({resp_fire, resp_request_id, resp_data, resp_latency, resp_is_write}
             !== {1'b1, 32'(i), dat[i], 32'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL bp_drain_%0d: got fire=%b id=%0d data=%h lat=%0d wr=%b required fire=1 id=%0d data=%h lat=3 wr=1",
                     i, resp_fire, resp_request_id, resp_data, resp_latency, resp_is_write, i, dat[i]);
         end
         tick();
      end
      resp_ready = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_empty: got %b required 0", resp_valid);
      end
   endtask

   task automatic test_stray();
      do_reset();
      req_valid = 1'b1; req_addr = 32'h300;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h99;
      #1;
      vectors++;
      if (proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_before: got %b required 0", proto_err);
      end
      tick();
      req_valid = 1'b0;
      vectors++;
      if ({proto_err, resp_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL stray_flag: got err=%b vld=%b required err=1 vld=0", proto_err, resp_valid);
      end
      mem_resp_valid = 1'b1; mem_resp_data = 32'h55;
      tick();
      mem_resp_valid = 1'b0;
      tick();
      vectors++;
      if ({proto_err, resp_valid, resp_request_id, resp_data, resp_latency}
          !== {1'b1, 1'b1, 32'd0, 32'h55, 32'd1}) begin
         miscompares++;
         $display("FAIL stray_sticky: got err=%b vld=%b id=%0d data=%h lat=%0d required 1 1 0 55 1",
                  proto_err, resp_valid, resp_request_id, resp_data, resp_latency);
      end
      do_reset();
      vectors++;
      if (proto_err !== 1'b0) begin
         miscompares++;
         $display("FAIL stray_cleared: got %b required 0", proto_err);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         req_valid = 1'b1; req_addr = 32'h400 + 32'(i * 4);
         tick();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 32'hB0 + 32'(i);
         tick();
      end
      mem_resp_valid = 1'b0;
      // Two cycles of simultaneous accept and fire at count 4.
      for (int i = 0; i < 2; i++) begin
         req_valid = 1'b1; req_addr = 32'h410 + 32'(i * 4);
         resp_ready = 1'b1;
         #1;
         vectors++;
         if ({resp_fire, req_ready, resp_request_id} !== {1'b1, 1'b1, 32'(i)}) begin
            miscompares++;
            $display("FAIL b2b_swap_%0d: got fire=%b rdy=%b id=%0d required fire=1 rdy=1 id=%0d",
                     i, resp_fire, req_ready, resp_request_id, i);
         end
         tick();
      end
      resp_ready = 1'b0;
      // Count must still be 4: exactly four more accepts fit.
      for (int i = 0; i < 4; i++) begin
         req_addr = 32'h418 + 32'(i * 4);
         #1;
         vectors++;
         if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_room_%0d: got %b required 1", i, req_ready);
         end
         tick();
      end
      req_valid = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_full: got %b required 0", req_ready);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 32'hC0 + 32'(i);
         tick();
         vectors++;
         if ({resp_valid, resp_request_id, resp_data} !== {1'b1, 32'(i + 2), 32'hC0 + 32'(i)}) begin
            miscompares++;
            $display("FAIL b2b_order_%0d: got vld=%b id=%0d data=%h required vld=1 id=%0d data=%h",
                     i, resp_valid, resp_request_id, resp_data, i + 2, 32'hC0 + 32'(i));
         end
      end
      mem_resp_valid = 1'b0;
      tick();
      resp_ready = 1'b0;
      vectors++;
      if ({resp_valid, req_ready, proto_err} !== 3'b010) begin
         miscompares++;
         $display("FAIL b2b_drained: got vld=%b rdy=%b err=%b required 0 1 0", resp_valid, req_ready, proto_err);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_addr = 32'h600 + 32'(i * 4); req_is_write = 1'b1;
         tick();
      end
      req_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 32'hE0 + 32'(i);
         tick();
      end
      mem_resp_valid = 1'b0;
      reset = 1'b0;
      tick();
      #1;
      vectors++;
      if ({req_ready, resp_valid, resp_fire, resp_addr, resp_data, resp_is_write,
           resp_request_id, resp_latency, global_cycle, proto_err} !== '0) begin
         miscompares++;
         $display("FAIL mid_reset_outputs: got rdy=%b vld=%b addr=%h data=%h wr=%b id=%0d cyc=%0d required all zero",
                  req_ready, resp_valid, resp_addr, resp_data, resp_is_write, resp_request_id, global_cycle);
      end
      reset     = 1'b1;
      exp_cycle = 0;
      req_valid = 1'b1; req_addr = 32'h500; req_is_write = 1'b0;
      #1;
      vectors++;
      if ({global_cycle, resp_valid, req_ready} !== {64'd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL mid_restart: got cyc=%0d vld=%b rdy=%b required 0 0 1", global_cycle, resp_valid, req_ready);
      end
      tick();
      req_valid      = 1'b0;
      mem_resp_valid = 1'b1; mem_resp_data = 32'hF00D;
      tick();
      mem_resp_valid = 1'b0;
      vectors++;
      if ({resp_valid, resp_request_id, resp_addr, resp_latency, global_cycle}
          !== {1'b1, 32'd0, 32'h500, 32'd1, 64'd2}) begin
         miscompares++;
         $display("FAIL mid_first_id: got vld=%b id=%0d addr=%h lat=%0d cyc=%0d required 1 0 500 1 2",
                  resp_valid, resp_request_id, resp_addr, resp_latency, global_cycle);
      end
   endtask

   initial begin
      clear_inputs();
      reset = 1'b0;
      test_reset();
      test_single_read();
      test_full();
      test_back_pressure();
      test_stray();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bank_response_tracker.md
# bank_response_tracker

Per-bank in-order request/response tracker between a bank scheduler and the physical memory response path. Each accepted request gets a request ID and an issue timestamp. The matching memory completion is attached to that request. Completed responses are buffered and presented downstream through a valid/ready handshake. The fire strobe, address, data, ID and cycle outputs drive the per-bank response performance-statistics logger directly.

## Interface
- RANK, 0, rank index of this bank; identification only.
- BANKGROUP, 0, bank-group index; identification only.
- BANK, 0, bank index; identification only.
- DEPTH, 8, max in-flight plus buffered entries; power of two, ≥2.
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  scheduler presents a request
- req_ready  out  1  tracker can allocate an entry
- req_addr  in  32  request address
- req_is_write  in  1  1 = write, 0 = read
- mem_resp_valid  in  1  physical memory completion; never back-pressured
- mem_resp_data  in  32  completion data
- resp_valid  out  1  oldest entry completed
- resp_ready  in  1  downstream accepts
- resp_fire  out  1  resp_valid && resp_ready
- resp_addr  out  32  address of head entry
- resp_data  out  32  completion data of head entry
- resp_is_write  out  1  type of head entry
- resp_request_id  out  32  ID of head entry
- resp_latency  out  32  completion cycle minus issue cycle, saturating
- global_cycle  out  64  free-running cycle count
- proto_err  out  1  sticky: completion arrived with nothing pending

## Operation
- global_cycle: 0 in reset, +1 every cycle, wraps at 2^64.
- Request ID counter: 0 in reset; +1 per accepted request; wraps at 2^32.
- Accept when req_valid && req_ready. The entry at the alloc pointer stores addr, is_write, current ID and issue_cycle = global_cycle. The alloc pointer advances and the count increments.
- req_ready = (count < DEPTH) && reset high; combinational from registered count. There is no same-cycle bypass from a dequeue.
- Completion handling is strictly in order. mem_resp_valid fills the entry at the fill pointer: data, latency, done=1. The fill pointer then advances.
- Latency = global_cycle − issue_cycle. If the difference is ≥ 2^32 it saturates to 0xFFFFFFFF.
- A completion with fill == alloc (nothing pending) is dropped and sets proto_err. A request accepted in the same cycle does not count as pending.
- resp_valid = head entry done. Head outputs are driven from registered entry fields.
- On resp_fire: done is cleared, head advances, count decrements.
- Simultaneous accept and fire change count by 0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.

## Timing
- Reset (reset low, sampled at clk): pointers, count, ID counter, global_cycle, proto_err and all done bits go to 0. All outputs are 0 while in reset, including req_ready. Reset mid-operation discards every entry with no responses emitted.
- Request accepted at cycle t gets issue_cycle = t's global_cycle.
- Completion at cycle u: resp_valid rises at u+1 at the earliest, if that entry is the head.
- resp_valid stays high and head outputs stay stable until fire.
- Full (count == DEPTH): req_ready = 0. Completions still fill entries.
- Empty: resp_valid = 0.

## Structure
- Package bank_tracker_pkg: entry struct (addr, is_write, id, issue_cycle, data, latency, done); width localparams (ADDR_W=32, DATA_W=32, ID_W=32, CYC_W=64); latency-saturate function.
- One sub-module is natural: bank_tracker_entry_ram, a DEPTH-entry register array with one allocate write port, one fill write port, one done-clear port and one read port at head.
- Pointer/count control and counters stay in the top module.

## Test plan
- Single read: req at global_cycle 10 (addr 0x40, ID 0), completion at cycle 25 with data 0xDEAD → resp_valid at 26, resp_request_id 0, resp_latency 15, resp_data 0xDEAD; resp_fire with resp_ready=1.
- Fill to 8 requests without completions → req_ready=0 on cycle after 8th accept. A 9th req_valid is not accepted. After one completion and one fire, req_ready returns to 1.
- Back-pressure: 3 completions with resp_ready=0 → resp_valid held, head outputs stable (ID 0). Raising resp_ready fires IDs 0,1,2 on consecutive cycles.
- Stray completion on empty tracker → proto_err=1 from next cycle and stays 1; no resp_valid; reset clears it.
- Same-cycle req accept and resp_fire at count 4 → count stays 4; IDs continue monotonically.
- Reset asserted with 5 entries in flight → next cycle all outputs 0. After release, the first accepted request gets ID 0 and global_cycle restarts at 0.
